fifo_ext: RTL

//  Parametrised single-clock FIFO with valid/ready handshake on both sides, for inter-stage event queues.

---
 rtl/fifo_ext.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_ext.sv
// Single-clock valid/ready FIFO with arbitrary depth, optional same-cycle bypass,
// occupancy/watermark outputs, synchronous flush and sticky error flags.
module fifo_ext #(
   parameter int unsigned  WIDTH     = 8,
   parameter int unsigned  DEPTH     = 16,
   parameter bit           BYPASS    = 1'b0,
   parameter int unsigned  AF_THRESH = 14,
   parameter int unsigned  AE_THRESH = 2,
   localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push_valid,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   output logic             pop_valid,
   output logic [WIDTH-1:0] pop_data,
   input  logic             pop_ready,
   output logic [CW-1:0]    count,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             err_overflow,
   output logic             err_underflow,
   input  logic             err_clear
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_front;
   logic [PW-1:0]    r_back;
   logic [CW-1:0]    r_count;
   logic             r_err_ovf;
   logic             r_err_unf;

   logic             w_bypass;
   logic             w_push_fire;
   logic             w_pop_fire;
   logic             w_wr;
   logic             w_rd;

   // Pointers wrap explicitly so any DEPTH works, not just powers of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake and read path, all derived from registered occupancy.
   always_comb begin
      push_ready   = (r_count < CW'(DEPTH));
      w_bypass     = (BYPASS != 1'b0) && (r_count == '0) && push_valid && pop_ready;
      pop_valid    = (r_count != '0) || w_bypass;
      pop_data     = w_bypass ? push_data : r_mem[r_front];
      w_push_fire  = push_valid && push_ready;
      w_pop_fire   = pop_valid && pop_ready;
      w_wr         = w_push_fire && !w_bypass;
      w_rd         = w_pop_fire && !w_bypass;
      count        = r_count;
      almost_full  = (r_count >= CW'(AF_THRESH));
      almost_empty = (r_count <= CW'(AE_THRESH));
      err_overflow  = r_err_ovf;
      err_underflow = r_err_unf;
   end

   // Storage is reset so the head word is never X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem <= '{default: '0};
      end else if (w_wr && !flush) begin
         r_mem[r_back] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_front <= '0;
         r_back  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_front <= '0;
         r_back  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_back  <= ptr_inc(r_back);
         if (w_rd) r_front <= ptr_inc(r_front);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end

   // Sticky protocol errors; clear wins over a same-cycle set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_ovf <= 1'b0;
         r_err_unf <= 1'b0;
      end else if (err_clear) begin
         r_err_ovf <= 1'b0;
         r_err_unf <= 1'b0;
      end else begin
         if (push_valid && !push_ready) r_err_ovf <= 1'b1;
         if (pop_ready && !pop_valid)   r_err_unf <= 1'b1;
      end
   end

endmodule
